mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Pipeline-to-data-memory access controller: validates and latches a load/store
// request, inserts WAIT_CYCLES idle cycles, performs a one-cycle access and reports completion.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = 1024,
  parameter int DEPTH_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic        ready,
  output logic [31:0] dataOut,
  output logic        err,
  output logic        dm_r_en,
  output logic        dm_w_en,
  output logic [31:0] dm_address,
  output logic [31:0] dm_dataIn,
  input  logic [31:0] dm_dataOut
);

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);
  localparam logic [31:0]   ADDR_LO   = 32'(BASE_ADDR);
  localparam logic [31:0]   ADDR_HI   = 32'(longint'(BASE_ADDR) + 4 * longint'(DEPTH_WORDS));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_data;
  logic          lat_store;
  logic          err_q;
  logic [31:0]   dout_q;
  logic          req;
  logic          bad_req;
  logic          accept;

  assign req    = mem_r_en | mem_w_en;
  assign accept = (state == ST_IDLE) && req;

  always_comb begin
    bad_req = (mem_r_en & mem_w_en)
            | (address[1:0] != 2'b00)
            | (address < ADDR_LO)
            | (address >= ADDR_HI);
  end

  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (bad_req) begin
            next_state = ST_DONE;
          end else if (WAIT_CYCLES > 0) begin
            next_state = ST_WAIT;
            next_count = WAIT_INIT;
          end else begin
            next_state = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        next_count = count - CW'(1);
        if (count == CW'(1)) begin
          next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Enables are gated by rst so a reset arriving during ACCESS cannot commit a write.
  always_comb begin
    ready   = 1'b0;
    dm_r_en = 1'b0;
    dm_w_en = 1'b0;
    case (state)
      ST_IDLE: ready = ~req;
      ST_ACCESS: begin
        dm_r_en = ~lat_store & ~rst;
        dm_w_en = lat_store & ~rst;
      end
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign dm_address = lat_addr;
  assign dm_dataIn  = lat_data;
  assign dataOut    = dout_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_store <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
      err_q <= accept && bad_req;
      if (accept) begin
        lat_addr  <= address;
        lat_data  <= dataIn;
        lat_store <= mem_w_en;
      end
      // A rejected request clears the load result; a completed load replaces it.
      if (accept && bad_req) begin
        dout_q <= '0;
      end else if ((state == ST_ACCESS) && !lat_store) begin
        dout_q <= dm_dataOut;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: one instance with WAIT_CYCLES=3 and one with WAIT_CYCLES=0,
// each backed by a small behavioural data memory, checked against a request-level scoreboard.
module tb_mem_access_ctrl;

  localparam int BASE  = 1024;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        r_en    [2];
  logic        w_en    [2];
  logic [31:0] addr    [2];
  logic [31:0] din     [2];
  logic        ready   [2];
  logic [31:0] dout    [2];
  logic        err     [2];
  logic        dm_r    [2];
  logic        dm_w    [2];
  logic [31:0] dm_addr [2];
  logic [31:0] dm_din  [2];
  logic [31:0] dm_dout [2];

  logic [31:0] mem     [2][DEPTH];
  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] exp_dout[2];
  logic        fill;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          k;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        scramble;
    logic        gap;
  } vec_t;

  typedef struct {
    logic        e;
    logic [31:0] d;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mem_access_ctrl #(.WAIT_CYCLES(3), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut3 (
    .clk(clk), .rst(rst[0]), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
    .address(addr[0]), .dataIn(din[0]), .ready(ready[0]), .dataOut(dout[0]),
    .err(err[0]), .dm_r_en(dm_r[0]), .dm_w_en(dm_w[0]), .dm_address(dm_addr[0]),
    .dm_dataIn(dm_din[0]), .dm_dataOut(dm_dout[0])
  );

  mem_access_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut0 (
    .clk(clk), .rst(rst[1]), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
    .address(addr[1]), .dataIn(din[1]), .ready(ready[1]), .dataOut(dout[1]),
    .err(err[1]), .dm_r_en(dm_r[1]), .dm_w_en(dm_w[1]), .dm_address(dm_addr[1]),
    .dm_dataIn(dm_din[1]), .dm_dataOut(dm_dout[1])
  );

  function automatic logic [3:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - 32'(BASE)) >> 2;
    return o[3:0];
  endfunction

  function automatic logic [31:0] pattern(input int k, input int i);
    return 32'hA500_0000 | 32'(k * 256 + i);
  endfunction

  assign dm_dout[0] = dm_r[0] ? mem[0][widx(dm_addr[0])] : 32'h0;
  assign dm_dout[1] = dm_r[1] ? mem[1][widx(dm_addr[1])] : 32'h0;

  // Behavioural data memory: combinational read, write committed at the clock edge.
  always @(posedge clk) begin
    if (fill) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < DEPTH; i++)
          mem[k][i] <= pattern(k, i);
    end else begin
      if (dm_w[0]) mem[0][widx(dm_addr[0])] <= dm_din[0];
      if (dm_w[1]) mem[1][widx(dm_addr[1])] <= dm_din[1];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic idleCycles(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      r_en[k] = 1'b0;
      w_en[k] = 1'b0;
      @(negedge clk);
      checkFlag("idle ready", ready[k], 1'b1);
      checkFlag("idle err", err[k], 1'b0);
      checkFlag("idle dm_r_en", dm_r[k], 1'b0);
      checkFlag("idle dm_w_en", dm_w[k], 1'b0);
      checkOutput("idle dataOut", dout[k], exp_dout[k]);
    end
  endtask

  task automatic doReset(input int k);
    @(posedge clk); #1;
    rst[k]  = 1'b1;
    r_en[k] = 1'b0;
    w_en[k] = 1'b0;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    exp_dout[k] = 32'h0;
    @(negedge clk);
    checkFlag("reset ready", ready[k], 1'b1);
    checkFlag("reset err", err[k], 1'b0);
    checkOutput("reset dataOut", dout[k], 32'h0);
    checkOutput("reset dm_address", dm_addr[k], 32'h0);
    checkOutput("reset dm_dataIn", dm_din[k], 32'h0);
  endtask

  // One request: expectation pushed when driven, popped when ready signals completion.
  task automatic applyStimulus(input vec_t v);
    int          k;
    int          w;
    int          c;
    logic        valid;
    logic [31:0] prev;
    exp_t        e;
    exp_t        got;
    bit          done;
    k = v.k;
    w = (k == 0) ? 3 : 0;
    valid = !(v.rd && v.wr) && (v.a[1:0] == 2'b00) &&
            (v.a >= 32'(BASE)) && (v.a < 32'(BASE + 4 * DEPTH));
    prev = exp_dout[k];
    if (!valid) exp_dout[k] = 32'h0;
    else if (v.rd) exp_dout[k] = ref_mem[k][widx(v.a)];
    else ref_mem[k][widx(v.a)] = v.d;
    e.e = !valid;
    e.d = exp_dout[k];
    e.lat = valid ? w + 2 : 1;
    sb.push_back(e);

    @(posedge clk); #1;
    r_en[k] = v.rd;
    w_en[k] = v.wr;
    addr[k] = v.a;
    din[k]  = v.d;
    c = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (c >= 1) begin
        checkOutput("dm_address", dm_addr[k], v.a);
        checkOutput("dm_dataIn", dm_din[k], v.d);
      end
      checkFlag("dm_r_en", dm_r[k], valid && v.rd && (c == w + 1));
      checkFlag("dm_w_en", dm_w[k], valid && v.wr && (c == w + 1));
      if (ready[k] === 1'b1) begin
        got = sb.pop_front();
        checkOutput("latency", 32'(c), 32'(got.lat));
        checkFlag("done err", err[k], got.e);
        checkOutput("done dataOut", dout[k], got.d);
        done = 1;
      end else if (c >= 20) begin
        got = sb.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL ready timeout: got no ready after %0d cycles expected %0d", c, got.lat);
        done = 1;
      end else begin
        checkFlag("busy err", err[k], 1'b0);
        checkOutput("busy dataOut", dout[k], prev);
        @(posedge clk); #1;
        if (v.scramble) begin
          r_en[k] = 1'($urandom_range(0, 1));
          w_en[k] = 1'($urandom_range(0, 1));
          addr[k] = $urandom;
          din[k]  = $urandom;
        end
        c++;
      end
    end
    if (v.gap) idleCycles(k, 2);
  endtask

  function automatic vec_t mk(input int k, input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic scr, input logic gap);
    vec_t v;
    v.k = k; v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.scramble = scr; v.gap = gap;
    return v;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; r_en[k] = 1'b0; w_en[k] = 1'b0;
      addr[k] = 32'h0; din[k] = 32'h0; exp_dout[k] = 32'h0;
      for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = pattern(k, i);
    end
    fill = 1'b1;
    @(posedge clk); #1;
    fill = 1'b0;
    doReset(0);
    doReset(1);

    vecs.push_back(mk(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 1'b1));
    vecs.push_back(mk(0, 1'b1, 1'b0, 32'd1028, 32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(0, 1'b1, 1'b0, 32'd1090, 32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(0, 1'b1, 1'b0, 32'd1088, 32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(0, 1'b1, 1'b1, 32'd1024, 32'h0BADF00D, 1'b0, 1'b1));
    vecs.push_back(mk(0, 1'b1, 1'b0, 32'd1028, 32'h0,        1'b1, 1'b1));
    vecs.push_back(mk(0, 1'b0, 1'b1, 32'd1084, 32'h12345678, 1'b1, 1'b1));
    vecs.push_back(mk(0, 1'b1, 1'b0, 32'd1020, 32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(0, 1'b1, 1'b0, 32'd1084, 32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(0, 1'b1, 1'b0, 32'd1036, 32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(1, 1'b0, 1'b1, 32'd1024, 32'h11111111, 1'b0, 1'b0));
    vecs.push_back(mk(1, 1'b0, 1'b1, 32'd1084, 32'h22222222, 1'b0, 1'b1));
    vecs.push_back(mk(1, 1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1, 1'b1, 1'b0, 32'd1084, 32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(1, 1'b1, 1'b0, 32'd1026, 32'h0,        1'b0, 1'b1));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Store aborted by reset in its second WAIT cycle must leave memory untouched.
    @(posedge clk); #1;
    w_en[0] = 1'b1; addr[0] = 32'd1032; din[0] = 32'h55AA55AA;
    @(negedge clk);
    checkFlag("abort c0 ready", ready[0], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkFlag("abort c1 dm_w_en", dm_w[0], 1'b0);
    @(posedge clk); #1;
    rst[0] = 1'b1; w_en[0] = 1'b0;
    @(negedge clk);
    checkFlag("abort c2 dm_w_en", dm_w[0], 1'b0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    exp_dout[0] = 32'h0;
    @(negedge clk);
    checkFlag("abort ready", ready[0], 1'b1);
    checkOutput("abort dataOut", dout[0], 32'h0);
    checkFlag("abort dm_w_en", dm_w[0], 1'b0);
    checkFlag("abort err", err[0], 1'b0);
    idleCycles(0, 4);
    applyStimulus(mk(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
